apb_timer_slave: RTL and testbench

- APB slave peripheral that sits directly downstream of axi_apb_bridge and consumes its APB master interface.
- Provides a 32-bit down-counting timer with prescaler, auto-reload and a level interrupt.
- Exposes a 4-register window at BASE_ADDR with configurable wait states and PSLVERR on illegal accesses.
- Serves as the bridge's first real APB target for bring-up and integration tests.

---
 rtl/apb_timer_slave.sv | 202 ++++++++++++++++++++
 tb/tb_apb_timer_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// APB timer slave: four-register window (CTRL, LOAD, COUNT, STATUS) in front of
// a 32-bit down-counter with an 8-bit prescaler, optional auto-reload and a
// registered level interrupt. Every access inserts WAIT_STATES wait cycles.
// Illegal accesses complete with PSLVERR and leave the registers untouched.
module apb_timer_slave #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int unsigned WAIT_STATES    = 1
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
    input  logic                      apb_pwrite,
    input  logic                      apb_psel,
    input  logic                      apb_penable,
    input  logic [APB_DATA_WIDTH-1:0] apb_pwdata,
    output logic [APB_DATA_WIDTH-1:0] apb_prdata,
    output logic                      apb_pready,
    output logic                      apb_pslverr,
    output logic                      timer_irq
);

    localparam int unsigned AW = APB_ADDR_WIDTH;
    localparam int unsigned DW = APB_DATA_WIDTH;

    // BASE_ADDR is expected to be 16-byte aligned.
    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
    localparam logic [3:0]    WS   = 4'(WAIT_STATES);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]  wait_cnt_reg,    wait_cnt_next;
    logic        en_reg,          en_next;
    logic        auto_reload_reg, auto_reload_next;
    logic        irq_en_reg,      irq_en_next;
    logic [7:0]  prescale_reg,    prescale_next;
    logic [31:0] load_reg,        load_next;
    logic [31:0] count_reg,       count_next;
    logic [7:0]  presc_cnt_reg,   presc_cnt_next;
    logic        expired_reg,     expired_next;
    logic        irq_reg,         irq_next;

    // ------------------------------------------------------------------
    // Address decode and handshake
    // ------------------------------------------------------------------
    logic [AW-1:0] offset;
    logic          in_range;
    logic          misaligned;
    logic [1:0]    reg_sel;
    logic          addr_err;
    logic          apb_access;
    logic          ready_int;
    logic          wr_commit;
    logic          rd_valid;
    logic [31:0]   rdata_mux;

    assign offset     = apb_paddr - BASE;
    assign in_range   = (apb_paddr >= BASE) && (offset[AW-1:4] == '0);
    assign misaligned = (apb_paddr[1:0] != 2'b00) || (offset[1:0] != 2'b00);
    assign reg_sel    = offset[3:2];
    assign addr_err   = !in_range || misaligned || (apb_pwrite && (reg_sel == REG_COUNT));
    assign apb_access = apb_psel && apb_penable;
    assign ready_int  = apb_access && (wait_cnt_reg == WS);
    assign wr_commit  = ready_int && apb_pwrite && !addr_err;
    assign rd_valid   = ready_int && !apb_pwrite && !addr_err && axi_aresetn;

    // Handshake outputs are forced low while reset is asserted.
    assign apb_pready  = ready_int && axi_aresetn;
    assign apb_pslverr = ready_int && addr_err && axi_aresetn;
    assign timer_irq   = irq_reg;

    // Register read multiplexer; unused CTRL bits read as zero.
    always_comb begin
        rdata_mux = '0;
        case (reg_sel)
            REG_CTRL:   rdata_mux = {16'h0000, prescale_reg, 5'b00000,
                                     irq_en_reg, auto_reload_reg, en_reg};
            REG_LOAD:   rdata_mux = load_reg;
            REG_COUNT:  rdata_mux = count_reg;
            REG_STATUS: rdata_mux = {31'h0, expired_reg};
            default:    rdata_mux = '0;
        endcase
    end

    // Read data is only presented on a completing, error-free read.
    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_prdata
            assign apb_prdata[gi] = rd_valid && rdata_mux[gi];
        end
    endgenerate

    // Wait-state counter: cleared in setup, climbs toward WAIT_STATES in access.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (apb_psel && !apb_penable) begin
            wait_cnt_next = 4'd0;
        end else if (apb_access && (wait_cnt_reg < WS)) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Timer and register write logic. Timer activity is evaluated first,
    // then bus writes override it where both touch the same field.
    // ------------------------------------------------------------------
    logic tick;
    logic set_expired;
    logic status_clear;

    always_comb begin
        en_next          = en_reg;
        auto_reload_next = auto_reload_reg;
        irq_en_next      = irq_en_reg;
        prescale_next    = prescale_reg;
        load_next        = load_reg;
        count_next       = count_reg;
        presc_cnt_next   = presc_cnt_reg;
        set_expired      = 1'b0;
        status_clear     = 1'b0;

        // >= keeps the prescaler bounded if PRESCALE is lowered mid-period.
        tick = en_reg && (presc_cnt_reg >= prescale_reg);

        if (en_reg) begin
            presc_cnt_next = tick ? 8'd0 : presc_cnt_reg + 8'd1;
        end

        if (tick) begin
            if (count_reg == 32'd0) begin
                set_expired = 1'b1;
                if (auto_reload_reg) begin
                    count_next = load_reg;
                end else begin
                    en_next = 1'b0;
                end
            end else begin
                count_next = count_reg - 32'd1;
            end
        end

        if (wr_commit) begin
            case (reg_sel)
                REG_CTRL: begin
                    en_next          = apb_pwdata[0];
                    auto_reload_next = apb_pwdata[1];
                    irq_en_next      = apb_pwdata[2];
                    prescale_next    = apb_pwdata[15:8];
                    if (!en_reg && apb_pwdata[0]) begin
                        presc_cnt_next = 8'd0;
                    end
                end
                REG_LOAD: begin
                    load_next  = apb_pwdata[31:0];
                    count_next = apb_pwdata[31:0];
                end
                REG_STATUS: begin
                    status_clear = apb_pwdata[0];
                end
                default: ;
            endcase
        end

        // A fresh expiry beats a simultaneous write-1-to-clear.
        expired_next = set_expired || (expired_reg && !status_clear);
        irq_next     = expired_reg && irq_en_reg;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wait_cnt_reg    <= 4'd0;
            en_reg          <= 1'b0;
            auto_reload_reg <= 1'b0;
            irq_en_reg      <= 1'b0;
            prescale_reg    <= 8'd0;
            load_reg        <= 32'd0;
            count_reg       <= 32'd0;
            presc_cnt_reg   <= 8'd0;
            expired_reg     <= 1'b0;
            irq_reg         <= 1'b0;
        end else begin
            wait_cnt_reg    <= wait_cnt_next;
            en_reg          <= en_next;
            auto_reload_reg <= auto_reload_next;
            irq_en_reg      <= irq_en_next;
            prescale_reg    <= prescale_next;
            load_reg        <= load_next;
            count_reg       <= count_next;
            presc_cnt_reg   <= presc_cnt_next;
            expired_reg     <= expired_next;
            irq_reg         <= irq_next;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Testbench for apb_timer_slave: directed scenarios followed by randomized
// APB traffic, all checked against a cycle-level behavioural timer model.
module tb_apb_timer_slave;

    localparam int unsigned WS   = 1;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic [31:0] apb_paddr;
    logic        apb_pwrite;
    logic        apb_psel;
    logic        apb_penable;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;
    logic        timer_irq;

    apb_timer_slave #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .BASE_ADDR      (BASE),
        .WAIT_STATES    (WS)
    ) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .apb_paddr   (apb_paddr),
        .apb_pwrite  (apb_pwrite),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .apb_pslverr (apb_pslverr),
        .timer_irq   (timer_irq)
    );

    always #5 axi_aclk = ~axi_aclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_en, m_ar, m_ie, m_exp, m_irq;
    bit   [7:0]  m_ps, m_pc;
    bit   [31:0] m_load, m_cnt;

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_irq = 0;
        m_ps = 0; m_pc = 0; m_load = 0; m_cnt = 0;
    endtask

    function automatic bit model_err(input bit wr, input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (addr < BASE || addr > BASE + 32'd15) return 1'b1;
        if (addr[1:0] != 2'b00) return 1'b1;
        if (wr && off == 32'd8) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        case (addr - BASE)
            32'd0:   return {16'h0, m_ps, 5'b0, m_ie, m_ar, m_en};
            32'd4:   return m_load;
            32'd8:   return m_cnt;
            default: return {31'h0, m_exp};
        endcase
    endfunction

    // One clock edge of the reference: timer progress, then an optional write.
    task automatic model_edge(input bit wr, input logic [31:0] addr, input logic [31:0] d);
        bit          n_en, n_exp, fired;
        bit   [7:0]  n_pc;
        bit   [31:0] n_cnt;
        n_en = m_en; n_pc = m_pc; n_cnt = m_cnt; fired = 0;
        if (m_en) begin
            if (m_pc >= m_ps) begin
                n_pc = 0;
                if (m_cnt == 0) begin
                    fired = 1;
                    if (m_ar) n_cnt = m_load; else n_en = 0;
                end else begin
                    n_cnt = m_cnt - 1;
                end
            end else begin
                n_pc = m_pc + 1;
            end
        end
        n_exp = fired ? 1'b1 : m_exp;
        m_irq = m_exp & m_ie;
        if (wr) begin
            case (addr - BASE)
                32'd0: begin
                    if (!m_en && d[0]) n_pc = 0;
                    n_en = d[0]; m_ar = d[1]; m_ie = d[2]; m_ps = d[15:8];
                end
                32'd4: begin m_load = d; n_cnt = d; end
                32'd12: if (d[0] && !fired) n_exp = 0;
                default: ;
            endcase
        end
        m_en = n_en; m_pc = n_pc; m_cnt = n_cnt; m_exp = n_exp;
    endtask

    // ---------------- drivers ----------------
    task automatic step(input bit wr, input logic [31:0] addr, input logic [31:0] d);
        @(posedge axi_aclk);
        model_edge(wr, addr, d);
        #1;
        check("timer_irq", {31'h0, timer_irq}, {31'h0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0);
    endtask

    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] d);
        bit          err;
        logic [31:0] exp_rd;
        apb_psel = 1'b1; apb_penable = 1'b0;
        apb_paddr = addr; apb_pwrite = wr; apb_pwdata = d;
        #1;
        check("setup_pready", {31'h0, apb_pready}, 32'h0);
        step(1'b0, 32'h0, 32'h0);
        apb_penable = 1'b1;
        for (int k = 0; k <= int'(WS); k++) begin
            #1;
            check("pready", {31'h0, apb_pready}, (k == int'(WS)) ? 32'h1 : 32'h0);
            if (k == int'(WS)) begin
                err = model_err(wr, addr);
                exp_rd = err ? 32'h0 : model_read(addr);
                check("pslverr", {31'h0, apb_pslverr}, {31'h0, err});
                if (!wr) check("prdata", apb_prdata, exp_rd);
                $display("xfer %s addr=%08h wdata=%08h rdata=%08h err=%0d",
                         wr ? "WR" : "RD", addr, d, apb_prdata, apb_pslverr);
            end
            step((k == int'(WS)) && wr && !model_err(wr, addr), addr, d);
        end
        apb_psel = 1'b0; apb_penable = 1'b0;
    endtask

    task automatic read_all();
        apb_xfer(1'b0, BASE + 32'h4, 32'h0);
        apb_xfer(1'b0, BASE + 32'h8, 32'h0);
        apb_xfer(1'b0, BASE + 32'hC, 32'h0);
        apb_xfer(1'b0, BASE + 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] addr, data;
        int          kind;

        axi_aresetn = 1'b0;
        apb_psel = 0; apb_penable = 0; apb_pwrite = 0; apb_paddr = 0; apb_pwdata = 0;
        model_reset();
        repeat (3) @(posedge axi_aclk);
        #1;
        check("rst_pready", {31'h0, apb_pready}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        axi_aresetn = 1'b1;

        // Reset values
        read_all();

        // One-shot countdown with interrupt
        apb_xfer(1'b1, BASE + 32'h4, 32'h0000_0003);
        apb_xfer(1'b1, BASE + 32'h0, 32'h0000_0005);
        apb_xfer(1'b0, BASE + 32'h8, 32'h0);
        idle(4);
        read_all();

        // Auto-reload with prescaler, then W1C
        apb_xfer(1'b1, BASE + 32'hC, 32'h1);
        apb_xfer(1'b1, BASE + 32'h4, 32'h0000_0002);
        apb_xfer(1'b1, BASE + 32'h0, 32'h0000_0303);
        for (int i = 0; i < 6; i++) apb_xfer(1'b0, BASE + 32'h8, 32'h0);
        idle(7);
        read_all();
        apb_xfer(1'b1, BASE + 32'hC, 32'h1);
        apb_xfer(1'b0, BASE + 32'hC, 32'h0);

        // LOAD=0 auto-reload expires every cycle: W1C always collides with a set
        apb_xfer(1'b1, BASE + 32'h4, 32'h0);
        apb_xfer(1'b1, BASE + 32'h0, 32'h0000_0007);
        apb_xfer(1'b1, BASE + 32'hC, 32'h1);
        apb_xfer(1'b0, BASE + 32'hC, 32'h0);
        apb_xfer(1'b1, BASE + 32'h0, 32'h0000_0004);
        apb_xfer(1'b1, BASE + 32'hC, 32'h1);
        idle(2);
        apb_xfer(1'b0, BASE + 32'hC, 32'h0);

        // Illegal accesses
        apb_xfer(1'b1, BASE + 32'h8, 32'h1234_5678);
        apb_xfer(1'b0, BASE + 32'h10, 32'h0);
        apb_xfer(1'b0, BASE + 32'h2, 32'h0);
        apb_xfer(1'b1, BASE - 32'h4, 32'hFFFF_FFFF);
        apb_xfer(1'b1, BASE + 32'h6, 32'hFFFF_FFFF);
        read_all();

        // Reset in the middle of an access with the timer running
        apb_xfer(1'b1, BASE + 32'h4, 32'h0000_0005);
        apb_xfer(1'b1, BASE + 32'h0, 32'h0000_FF05);
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = BASE + 32'h8;
        step(1'b0, 32'h0, 32'h0);
        apb_penable = 1'b1;
        #2;
        axi_aresetn = 1'b0;
        model_reset();
        #1;
        check("midrst_pready", {31'h0, apb_pready}, 32'h0);
        check("midrst_pslverr", {31'h0, apb_pslverr}, 32'h0);
        check("midrst_prdata", apb_prdata, 32'h0);
        check("midrst_irq", {31'h0, timer_irq}, 32'h0);
        @(posedge axi_aclk);
        #1;
        check("inrst_pready", {31'h0, apb_pready}, 32'h0);
        apb_psel = 1'b0; apb_penable = 1'b0;
        axi_aresetn = 1'b1;
        read_all();

        // LOAD write / readback
        apb_xfer(1'b1, BASE + 32'h4, 32'hDEAD_BEEF);
        apb_xfer(1'b0, BASE + 32'h4, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 11));
            data = $urandom;
            case (kind)
                0, 1: begin addr = BASE; data = {16'h0, 6'h0, 2'($urandom_range(0, 3)), 5'h0, 3'($urandom)}; end
                2, 3: begin addr = BASE + 32'h4; data = $urandom_range(0, 6); end
                4:    addr = BASE + 32'hC;
                5:    addr = BASE + 32'h8;
                6:    addr = BASE + 32'h10 + 32'($urandom_range(0, 3) * 4);
                7:    addr = BASE + 32'($urandom_range(1, 15));
                default: addr = BASE + 32'($urandom_range(0, 3) * 4);
            endcase
            apb_xfer(kind < 5 ? ($urandom_range(0, 3) != 0) : 1'($urandom), addr, data);
            idle(int'($urandom_range(0, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
